// File: rtl/div_array_scheduler_pkg.sv
// Shared widths, constants and FSM state type for the divider scheduler.
package div_sched_pkg;

    localparam int N_W = 16;
    localparam int D_W = 8;
    localparam int Q_W = 8;

    // Quotient reported when the divisor is zero (divider array bypassed).
    localparam logic [Q_W-1:0] DZ_Q = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_e;

    // Quotient cannot fit in Q_W bits when the dividend high byte reaches the divisor.
    function automatic logic calc_ovf(input logic [N_W-1:0] n, input logic [D_W-1:0] d);
        return (d != '0) && (n[N_W-1:N_W-D_W] >= d);
    endfunction

endpackage

// File: rtl/div_array_scheduler_if.sv
// Request, divider-array and response signals of the scheduler.
// master: the scheduler itself; slave: requesters, array and consumer.
interface div_array_scheduler_if #(
    parameter int NREQ = 4
);
    import div_sched_pkg::*;

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*N_W-1:0] req_n;
    logic [NREQ*D_W-1:0] req_d;

    logic [N_W-1:0]      div_n;
    logic [D_W-1:0]      div_d;
    logic [Q_W-1:0]      div_q;
    logic [D_W-1:0]      div_r;

    logic                resp_valid;
    logic                resp_ready;
    logic [IDW-1:0]      resp_id;
    logic [Q_W-1:0]      resp_q;
    logic [D_W-1:0]      resp_r;
    logic                resp_dz;
    logic                resp_ovf;

    modport master (
        input  req_valid, req_n, req_d, div_q, div_r, resp_ready,
        output req_ready, div_n, div_d,
               resp_valid, resp_id, resp_q, resp_r, resp_dz, resp_ovf
    );

    modport slave (
        output req_valid, req_n, req_d, div_q, div_r, resp_ready,
        input  req_ready, div_n, div_d,
               resp_valid, resp_id, resp_q, resp_r, resp_dz, resp_ovf
    );

endinterface

// File: rtl/div_array_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr_i and wraps modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o
);

    // First requester found at or after the pointer wins.
    always_comb begin
        int  j;
        logic found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/div_array_scheduler.sv
// Shares one combinational 16/8 array divider between NREQ requesters.
// Operands are registered at acceptance and held for the settle window;
// results come back on a single tagged response channel.
//
// state  | meaning
// IDLE   | arbitrating; one-hot grant on req_ready
// SETTLE | operands held, counting down the array settle window
// RESP   | result held on resp_* until resp_ready
module div_array_scheduler #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    div_array_scheduler_if.master bus
);
    import div_sched_pkg::*;

    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [N_W-1:0]   div_n_q, div_n_d;
    logic [D_W-1:0]   div_d_q, div_d_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [Q_W-1:0]   q_q, q_d;
    logic [D_W-1:0]   r_q, r_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gidx;
    logic [N_W-1:0]   n_sel;
    logic [D_W-1:0]   d_sel;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gidx)
    );

    assign n_sel = bus.req_n[int'(gidx)*N_W +: N_W];
    assign d_sel = bus.req_d[int'(gidx)*D_W +: D_W];

    // Next-state and datapath load decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        div_n_d = div_n_q;
        div_d_d = div_d_q;
        id_d    = id_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    div_n_d = n_sel;
                    div_d_d = d_sel;
                    id_d    = gidx;
                    ovf_d   = calc_ovf(n_sel, d_sel);
                    ptr_d   = (gidx == IDW'(NREQ-1)) ? '0 : gidx + IDW'(1);
                    if (d_sel == '0) begin
                        q_d     = DZ_Q;
                        r_d     = n_sel[D_W-1:0];
                        dz_d    = 1'b1;
                        state_d = RESP;
                    end else begin
                        dz_d    = 1'b0;
                        cnt_d   = CNT_W'(SETTLE-1);
                        state_d = div_sched_pkg::SETTLE;
                    end
                end
            end
            div_sched_pkg::SETTLE: begin
                if (cnt_q == '0) begin
                    q_d     = bus.div_q;
                    r_d     = bus.div_r;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointer, operand and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            ptr_q   <= '0;
            div_n_q <= '0;
            div_d_q <= '0;
            id_q    <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            div_n_q <= div_n_d;
            div_d_q <= div_d_d;
            id_q    <= id_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    // Grant is suppressed while reset is asserted so no requester sees a false ready.
    assign bus.req_ready  = (state_q == IDLE && rst_n) ? grant : '0;
    assign bus.div_n      = div_n_q;
    assign bus.div_d      = div_d_q;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_id    = id_q;
    assign bus.resp_q     = q_q;
    assign bus.resp_r     = r_q;
    assign bus.resp_dz    = dz_q;
    assign bus.resp_ovf   = ovf_q;

endmodule

// File: tb/tb_div_array_scheduler.sv
// Directed bench for div_array_scheduler with a behavioural divider array.
module tb_div_array_scheduler;

    localparam int NREQ   = 4;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    div_array_scheduler_if #(.NREQ(NREQ)) bus();

    div_array_scheduler #(
        .NREQ   (NREQ),
        .SETTLE (SETTLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Array model: exact division of the operands, appearing one edge after they
    // change, so it is only correct at the SETTLE=2 capture edge (stale before).
    always @(posedge clk) begin
        if (bus.div_d != 8'd0) begin
            bus.div_q <= 8'(bus.div_n / 16'(bus.div_d));
            bus.div_r <= 8'(bus.div_n % 16'(bus.div_d));
        end else begin
            bus.div_q <= 8'hAA;
            bus.div_r <= 8'h55;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_div_n"},     32'(bus.div_n), 32'd0);
        chk({tag, "_div_d"},     32'(bus.div_d), 32'd0);
        chk({tag, "_resp_valid"},32'(bus.resp_valid), 32'd0);
        chk({tag, "_resp_id"},   32'(bus.resp_id), 32'd0);
        chk({tag, "_resp_q"},    32'(bus.resp_q), 32'd0);
        chk({tag, "_resp_r"},    32'(bus.resp_r), 32'd0);
        chk({tag, "_resp_dz"},   32'(bus.resp_dz), 32'd0);
        chk({tag, "_resp_ovf"},  32'(bus.resp_ovf), 32'd0);
    endtask

    // Issue one request, check the grant, latched operands, latency and result.
    task automatic run_op(input int id, input logic [15:0] n, input logic [7:0] d,
                          input int lat, input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input logic eovf);
        int cyc;
        @(negedge clk);
        bus.req_valid           = '0;
        bus.req_valid[id]       = 1'b1;
        bus.req_n[id*16 +: 16]  = n;
        bus.req_d[id*8 +: 8]    = d;
        #1;
        chk("grant", 32'(bus.req_ready), 32'd1 << id);
        @(negedge clk);
        bus.req_valid = '0;
        chk("div_n_latched", 32'(bus.div_n), 32'(n));
        chk("div_d_latched", 32'(bus.div_d), 32'(d));
        cyc = 0;
        while (!bus.resp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency",  32'(cyc), 32'(lat));
        chk("resp_id",  32'(bus.resp_id), 32'(id));
        chk("resp_q",   32'(bus.resp_q), 32'(eq));
        chk("resp_r",   32'(bus.resp_r), 32'(er));
        chk("resp_dz",  32'(bus.resp_dz), 32'(edz));
        chk("resp_ovf", 32'(bus.resp_ovf), 32'(eovf));
    endtask

    task automatic ack();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        #1;
        chk("resp_drop", 32'(bus.resp_valid), 32'd0);
    endtask

    logic [15:0] fn [NREQ] = '{16'd100, 16'd200, 16'd300, 16'd400};
    logic [7:0]  fd [NREQ] = '{8'd3,    8'd5,    8'd7,    8'd11};
    logic [7:0]  fq [NREQ] = '{8'd33,   8'd40,   8'd42,   8'd36};
    logic [7:0]  fr [NREQ] = '{8'd1,    8'd0,    8'd6,    8'd4};

    initial begin
        int          grants;
        int          exp_id;
        int          last_gid;
        logic        gprev;
        logic [15:0] prev_dn;

        bus.req_valid  = '0;
        bus.req_n      = '0;
        bus.req_d      = '0;
        bus.resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk_reset("rst_low");
        rst_n = 1'b1;
        #1;
        chk_reset("rst_rel");

        // Single request, divide by zero, overflow; pointer moves 1 -> 2 -> 3 -> 0.
        run_op(1, 16'd200,  8'd7, SETTLE, 8'd28,  8'd4,  1'b0, 1'b0);
        ack();
        run_op(2, 16'h1234, 8'd0, 0,      8'hFF,  8'h34, 1'b1, 1'b0);
        ack();
        run_op(3, 16'h0A07, 8'd5, SETTLE, 8'h01,  8'h02, 1'b0, 1'b1);
        ack();

        // Fairness: everyone requests continuously, consumer always ready.
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            bus.req_n[i*16 +: 16] = fn[i];
            bus.req_d[i*8 +: 8]   = fd[i];
        end
        bus.req_valid  = '1;
        bus.resp_ready = 1'b1;
        grants   = 0;
        exp_id   = 0;
        last_gid = 0;
        gprev    = 1'b0;
        prev_dn  = bus.div_n;
        for (int c = 0; c < 60 && grants < 8; c++) begin
            #1;
            if (bus.div_n !== prev_dn) begin
                chk("div_chg_at_grant", 32'(gprev), 32'd1);
            end
            prev_dn = bus.div_n;
            if (bus.resp_valid) begin
                chk("fair_resp_id", 32'(bus.resp_id), 32'(last_gid));
                chk("fair_resp_q",  32'(bus.resp_q), 32'(fq[last_gid]));
                chk("fair_resp_r",  32'(bus.resp_r), 32'(fr[last_gid]));
            end
            gprev = |bus.req_ready;
            if (|bus.req_ready) begin
                chk("fair_grant", 32'(bus.req_ready), 32'd1 << exp_id);
                last_gid = exp_id;
                exp_id   = (exp_id + 1) % NREQ;
                grants++;
            end
            @(negedge clk);
        end
        chk("fair_count", 32'(grants), 32'd8);
        bus.req_valid = '0;
        repeat (SETTLE + 3) @(negedge clk);
        bus.resp_ready = 1'b0;
        #1;
        chk("fair_idle", 32'(bus.resp_valid), 32'd0);

        // Backpressure: result must hold while requester 1 waits.
        run_op(0, 16'd1000, 8'd9, SETTLE, 8'd111, 8'd1, 1'b0, 1'b0);
        bus.req_valid[1]    = 1'b1;
        bus.req_n[16 +: 16] = 16'd50;
        bus.req_d[8 +: 8]   = 8'd4;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid",     32'(bus.resp_valid), 32'd1);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_q",  32'({bus.resp_id, bus.resp_q, bus.resp_r, bus.resp_dz, bus.resp_ovf}),
                         32'({2'd0, 8'd111, 8'd1, 1'b0, 1'b0}));
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        #1;
        chk("bp_after_valid", 32'(bus.resp_valid), 32'd0);
        chk("bp_next_grant",  32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        bus.req_valid = '0;
        chk("bp_next_div_n", 32'(bus.div_n), 32'd50);

        // Reset one cycle into the settle window.
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = '1;
        #1;
        chk_reset("rst_mid");
        @(negedge clk);
        bus.req_valid = '0;
        rst_n         = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_resp_after_rst", 32'(bus.resp_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
